// File: rtl/pcie_tx_pkg.sv
// Shared types and constants for the PCIe TX arbiter.
// State encoding, tuser bit map, drop counter width, helpers.
package pcie_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_FLUSH = 2'd2
  } tx_state_e;

  localparam int TUSER_W           = 4;
  localparam int TUSER_ECRC_GEN    = 0;
  localparam int TUSER_ERR_FWD     = 1;
  localparam int TUSER_STREAMED    = 2;
  localparam int TUSER_SRC_DSC     = 3;
  // The core names src_dsc "discontinue" in its docs.
  localparam int TUSER_DISCONTINUE = TUSER_SRC_DSC;

  localparam int DROP_CNT_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [DROP_CNT_W-1:0] sat_inc(
    input logic [DROP_CNT_W-1:0] v
  );
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pcie_rr_pick.sv
// Round-robin first-set finder over NUM_CHAN requests.
// Returns the first set request at or after ptr, wrapping.
module pcie_rr_pick
  import pcie_tx_pkg::*;
#(
  parameter int NUM_CHAN = 4,
  localparam int IDX_W = idx_w(NUM_CHAN)
) (
  input  logic [NUM_CHAN-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic                found,
  output logic [IDX_W-1:0]    idx
);

  logic [IDX_W:0] sum;

  // Scan offsets 0..NUM_CHAN-1 from ptr, keep the first hit.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_CHAN))
        sum = sum - (IDX_W+1)'(NUM_CHAN);
      if (!found && req[sum[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// N-channel packet round-robin arbiter onto the PCIe core TX stream.
// Optional per-channel packet counters: PCIE_TX_ARB_STATS_EN.
module pcie_tx_arbiter
  import pcie_tx_pkg::*;
#(
  parameter int         C_DATA_WIDTH = 64,
  parameter int         KEEP_WIDTH   = C_DATA_WIDTH/8,
  parameter int         NUM_CHAN     = 4,
  parameter logic [5:0] BUF_AV_MIN   = 6'd2
) (
  input  logic                         sys_clk,
  input  logic                         sys_reset_n,
  input  logic                         user_lnk_up,
  input  logic [5:0]                   tx_buf_av,
  input  logic                         tx_cfg_req,
  output logic                         tx_cfg_gnt,
  input  logic [NUM_CHAN*C_DATA_WIDTH-1:0] ch_tdata,
  input  logic [NUM_CHAN*KEEP_WIDTH-1:0]   ch_tkeep,
  input  logic [NUM_CHAN*TUSER_W-1:0]      ch_tuser,
  input  logic [NUM_CHAN-1:0]          ch_tlast,
  input  logic [NUM_CHAN-1:0]          ch_tvalid,
  output logic [NUM_CHAN-1:0]          ch_tready,
  output logic [C_DATA_WIDTH-1:0]      s_axis_tx_tdata,
  output logic [KEEP_WIDTH-1:0]        s_axis_tx_tkeep,
  output logic [TUSER_W-1:0]           s_axis_tx_tuser,
  output logic                         s_axis_tx_tlast,
  output logic                         s_axis_tx_tvalid,
  input  logic                         s_axis_tx_tready,
  output logic [DROP_CNT_W-1:0]        drop_count
`ifdef PCIE_TX_ARB_STATS_EN
  ,
  output logic [NUM_CHAN*32-1:0]       pkt_count
`endif
);

  localparam int IDX_W = idx_w(NUM_CHAN);

  tx_state_e            state, state_n;
  logic [IDX_W-1:0]     grant, grant_n;
  logic [IDX_W-1:0]     rr_ptr, rr_n;
  logic [IDX_W-1:0]     grant_nxt;
  logic [DROP_CNT_W-1:0] drop_q, drop_n;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic                 start_ok;
  logic                 idle_st, xfer_st, flush_st;

  logic [C_DATA_WIDTH-1:0] dat_a  [NUM_CHAN];
  logic [KEEP_WIDTH-1:0]   keep_a [NUM_CHAN];
  logic [TUSER_W-1:0]      user_a [NUM_CHAN];

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_unpack
    assign dat_a[i]  = ch_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
    assign keep_a[i] = ch_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
    assign user_a[i] = ch_tuser[i*TUSER_W +: TUSER_W];
  end

  pcie_rr_pick #(
    .NUM_CHAN (NUM_CHAN)
  ) u_pick (
    .req   (ch_tvalid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign s_axis_tx_tdata = dat_a[grant];
  assign s_axis_tx_tkeep = keep_a[grant];
  assign s_axis_tx_tuser = user_a[grant];
  assign s_axis_tx_tlast = ch_tlast[grant];
  assign drop_count      = drop_q;

  assign grant_nxt = (grant == IDX_W'(NUM_CHAN-1)) ?
                     '0 : grant + IDX_W'(1);

  // Core config requests win over new packet starts.
  assign start_ok = !tx_cfg_req && user_lnk_up &&
                    (tx_buf_av >= BUF_AV_MIN) && pick_found;

  // Link loss in XFER sinks beats in the very same cycle.
  assign idle_st  = (state == ST_IDLE);
  assign xfer_st  = (state == ST_XFER) && user_lnk_up;
  assign flush_st = (state == ST_FLUSH) ||
                    ((state == ST_XFER) && !user_lnk_up);

  // State, grant, pointer and drop counter registers.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      drop_q <= '0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      rr_ptr <= rr_n;
      drop_q <= drop_n;
    end
  end

  // Next state, handshakes and packet-end bookkeeping.
  always_comb begin
    state_n          = state;
    grant_n          = grant;
    rr_n             = rr_ptr;
    drop_n           = drop_q;
    tx_cfg_gnt       = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    ch_tready        = '0;
    unique case (1'b1)
      idle_st: begin
        tx_cfg_gnt = 1'b1;
        if (start_ok) begin
          grant_n = pick_idx;
          state_n = ST_XFER;
        end
      end
      xfer_st: begin
        s_axis_tx_tvalid = ch_tvalid[grant];
        ch_tready[grant] = s_axis_tx_tready;
        if (ch_tvalid[grant] && s_axis_tx_tready &&
            ch_tlast[grant]) begin
          rr_n    = grant_nxt;
          state_n = ST_IDLE;
        end
      end
      flush_st: begin
        ch_tready[grant] = 1'b1;
        if (ch_tvalid[grant] && ch_tlast[grant]) begin
          drop_n  = sat_inc(drop_q);
          rr_n    = grant_nxt;
          state_n = ST_IDLE;
        end else begin
          state_n = ST_FLUSH;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

`ifdef PCIE_TX_ARB_STATS_EN
  logic        fwd_done;
  logic [31:0] pkt_q [NUM_CHAN];

  assign fwd_done = xfer_st && ch_tvalid[grant] &&
                    s_axis_tx_tready && ch_tlast[grant];

  // Count packets completed towards the core, per channel.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      for (int i = 0; i < NUM_CHAN; i++)
        pkt_q[i] <= '0;
    end else if (fwd_done) begin
      pkt_q[grant] <= pkt_q[grant] + 32'd1;
    end
  end

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_stats
    assign pkt_count[i*32 +: 32] = pkt_q[i];
  end
`endif

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Bench for pcie_tx_arbiter: directed steps plus random packets.
// Expected stream comes from a packet-level round-robin model.
module tb_pcie_tx_arbiter;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int NC = 4;

  logic              sys_clk = 1'b0;
  logic              sys_reset_n;
  logic              user_lnk_up;
  logic [5:0]        tx_buf_av;
  logic              tx_cfg_req;
  logic              tx_cfg_gnt;
  logic [NC*DW-1:0]  ch_tdata;
  logic [NC*KW-1:0]  ch_tkeep;
  logic [NC*4-1:0]   ch_tuser;
  logic [NC-1:0]     ch_tlast;
  logic [NC-1:0]     ch_tvalid;
  logic [NC-1:0]     ch_tready;
  logic [DW-1:0]     s_axis_tx_tdata;
  logic [KW-1:0]     s_axis_tx_tkeep;
  logic [3:0]        s_axis_tx_tuser;
  logic              s_axis_tx_tlast;
  logic              s_axis_tx_tvalid;
  logic              s_axis_tx_tready;
  logic [15:0]       drop_count;
`ifdef PCIE_TX_ARB_STATS_EN
  logic [NC*32-1:0]  pkt_count;
  int unsigned       pkt_m [NC];
`endif

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [3:0]    u;
    logic          l;
    int            ch;
  } beat_t;

  beat_t       srcq [NC][$];
  beat_t       expq [$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          rr_m = 0;
  bit          rand_mode = 1'b0;
  bit          flush_mode = 1'b0;
  logic [NC-1:0] fire = '0;

  always #5 sys_clk = ~sys_clk;

  pcie_tx_arbiter #(
    .C_DATA_WIDTH (DW),
    .KEEP_WIDTH   (KW),
    .NUM_CHAN     (NC),
    .BUF_AV_MIN   (6'd2)
  ) dut (
    .sys_clk          (sys_clk),
    .sys_reset_n      (sys_reset_n),
    .user_lnk_up      (user_lnk_up),
    .tx_buf_av        (tx_buf_av),
    .tx_cfg_req       (tx_cfg_req),
    .tx_cfg_gnt       (tx_cfg_gnt),
    .ch_tdata         (ch_tdata),
    .ch_tkeep         (ch_tkeep),
    .ch_tuser         (ch_tuser),
    .ch_tlast         (ch_tlast),
    .ch_tvalid        (ch_tvalid),
    .ch_tready        (ch_tready),
    .s_axis_tx_tdata  (s_axis_tx_tdata),
    .s_axis_tx_tkeep  (s_axis_tx_tkeep),
    .s_axis_tx_tuser  (s_axis_tx_tuser),
    .s_axis_tx_tlast  (s_axis_tx_tlast),
    .s_axis_tx_tvalid (s_axis_tx_tvalid),
    .s_axis_tx_tready (s_axis_tx_tready),
    .drop_count       (drop_count)
`ifdef PCIE_TX_ARB_STATS_EN
    ,
    .pkt_count        (pkt_count)
`endif
  );

  task automatic chk(input logic [127:0] obs,
                     input logic [127:0] exp,
                     input string tag);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NC; i++) begin
      if (srcq[i].size() > 0) begin
        ch_tvalid[i]          = 1'b1;
        ch_tdata[i*DW +: DW]  = srcq[i][0].d;
        ch_tkeep[i*KW +: KW]  = srcq[i][0].k;
        ch_tuser[i*4 +: 4]    = srcq[i][0].u;
        ch_tlast[i]           = srcq[i][0].l;
      end else begin
        ch_tvalid[i]          = 1'b0;
        ch_tdata[i*DW +: DW]  = '0;
        ch_tkeep[i*KW +: KW]  = '0;
        ch_tuser[i*4 +: 4]    = '0;
        ch_tlast[i]           = 1'b0;
      end
    end
  endtask

  task automatic push_pkt(input int ch, input int len);
    beat_t x;
    for (int b = 0; b < len; b++) begin
      x.d  = {$urandom, $urandom};
      x.k  = KW'($urandom);
      x.u  = 4'($urandom);
      x.l  = (b == len - 1);
      x.ch = ch;
      srcq[ch].push_back(x);
    end
  endtask

  // Whole packets, round robin over channels holding data.
  task automatic build_expected();
    beat_t cp [NC][$];
    beat_t x;
    int    ch;
    bit    more;
    for (int i = 0; i < NC; i++) cp[i] = srcq[i];
    more = 1'b1;
    while (more) begin
      ch = -1;
      for (int o = 0; o < NC; o++) begin
        if (ch < 0 && cp[(rr_m + o) % NC].size() > 0)
          ch = (rr_m + o) % NC;
      end
      if (ch < 0) begin
        more = 1'b0;
      end else begin
        do begin
          x = cp[ch].pop_front();
          expq.push_back(x);
        end while (!x.l);
        rr_m = (ch + 1) % NC;
`ifdef PCIE_TX_ARB_STATS_EN
        pkt_m[ch]++;
`endif
      end
    end
  endtask

  // Check at negedge+1, then advance one clock, return at negedge.
  task automatic tick();
    beat_t e;
    int    ec;
    logic [NC-1:0] other;
    #1;
    ec = (expq.size() > 0) ? expq[0].ch : -1;
    if (!flush_mode) begin
      other = ch_tready;
      if (ec >= 0) other[ec] = 1'b0;
      chk(other, 0, "tready_other");
      if (ec >= 0 && s_axis_tx_tvalid)
        chk(ch_tready[ec], s_axis_tx_tready, "tready_mirror");
    end
    fire = ch_tvalid & ch_tready;
    if (s_axis_tx_tvalid && s_axis_tx_tready) begin
      chk(expq.size() > 0, 1, "beat_expected");
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk({s_axis_tx_tdata, s_axis_tx_tkeep,
             s_axis_tx_tuser, s_axis_tx_tlast},
            {e.d, e.k, e.u, e.l}, "out_beat");
      end
    end
    @(posedge sys_clk);
    #1;
    for (int i = 0; i < NC; i++)
      if (fire[i] && srcq[i].size() > 0)
        void'(srcq[i].pop_front());
    if (rand_mode) begin
      s_axis_tx_tready = 1'($urandom);
      tx_buf_av        = 6'($urandom_range(0, 15));
      tx_cfg_req       = ($urandom_range(0, 3) == 0);
    end
    drive();
    @(negedge sys_clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (expq.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk(expq.size(), 0, "drain_timeout");
  endtask

  task automatic wait_tvalid(input int budget);
    int n = 0;
    while (!s_axis_tx_tvalid && n < budget) begin
      tick();
      n++;
    end
    chk(s_axis_tx_tvalid, 1, "wait_tvalid");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    sys_reset_n      = 1'b1;
    user_lnk_up      = 1'b1;
    tx_buf_av        = 6'd10;
    tx_cfg_req       = 1'b0;
    s_axis_tx_tready = 1'b1;
    drive();
    #2 sys_reset_n = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk(tx_cfg_gnt, 1, "rst_cfg_gnt");
    chk(s_axis_tx_tvalid, 0, "rst_tvalid");
    chk(ch_tready, 0, "rst_ch_tready");
    chk(drop_count, 0, "rst_drop_count");
`ifdef PCIE_TX_ARB_STATS_EN
    chk(pkt_count, 0, "rst_pkt_count");
`endif
    sys_reset_n = 1'b1;
    tick();

    // Two 3-beat packets on ch0, ch2, then rr at 3.
    push_pkt(0, 3);
    push_pkt(2, 3);
    drive();
    build_expected();
    drain(50);
    push_pkt(0, 1);
    push_pkt(3, 1);
    drive();
    build_expected();
    drain(50);

    // Buffer threshold gating.
    tx_buf_av = 6'd1;
    push_pkt(1, 2);
    drive();
    build_expected();
    repeat (3) begin
      tick();
      chk(s_axis_tx_tvalid, 0, "bufav_hold");
      chk(ch_tready, 0, "bufav_tready");
    end
    tx_buf_av = 6'd2;
    tick();
    chk(s_axis_tx_tvalid, 1, "bufav_start");
    drain(20);
    tx_buf_av = 6'd10;

    // Config request mid-packet on ch3.
    push_pkt(3, 4);
    drive();
    build_expected();
    wait_tvalid(10);
    tx_cfg_req = 1'b1;
    #1;
    chk(tx_cfg_gnt, 0, "cfg_hold_first");
    repeat (3) begin
      tick();
      chk(tx_cfg_gnt, 0, "cfg_hold");
    end
    tick();
    chk(tx_cfg_gnt, 1, "cfg_idle_gnt");
    push_pkt(0, 2);
    drive();
    build_expected();
    repeat (3) begin
      tick();
      chk(s_axis_tx_tvalid, 0, "cfg_block");
      chk(tx_cfg_gnt, 1, "cfg_gnt_idle");
    end
    tx_cfg_req = 1'b0;
    drain(20);

    // Core tready toggling on a 4-beat packet.
    push_pkt(2, 4);
    drive();
    build_expected();
    n = 0;
    while (expq.size() > 0 && n < 40) begin
      s_axis_tx_tready = ~s_axis_tx_tready;
      tick();
      n++;
    end
    chk(expq.size(), 0, "toggle_drain");
    s_axis_tx_tready = 1'b1;

    // Random packets with random tready, buf_av, cfg_req.
    rand_mode = 1'b1;
    repeat (6) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 1) == 1)
          push_pkt(c, $urandom_range(1, 5));
        if ($urandom_range(0, 3) == 0)
          push_pkt(c, $urandom_range(1, 5));
      end
      drive();
      build_expected();
      drain(600);
    end
    rand_mode        = 1'b0;
    s_axis_tx_tready = 1'b1;
    tx_buf_av        = 6'd10;
    tx_cfg_req       = 1'b0;
`ifdef PCIE_TX_ARB_STATS_EN
    for (int c = 0; c < NC; c++)
      chk(pkt_count[c*32 +: 32], pkt_m[c], "pkt_count");
`endif

    // Link loss after beat 2 of 5 on ch1.
    push_pkt(1, 5);
    drive();
    expq.push_back(srcq[1][0]);
    expq.push_back(srcq[1][1]);
    wait_tvalid(10);
    tick();
    tick();
    user_lnk_up = 1'b0;
    flush_mode  = 1'b1;
    #1;
    chk(s_axis_tx_tvalid, 0, "flush_tvalid");
    chk(ch_tready, 4'b0010, "flush_tready");
    repeat (3) tick();
    chk(srcq[1].size(), 0, "flush_sunk");
    chk(drop_count, 1, "drop_count");
    chk(ch_tready, 0, "lnkdn_idle_tready");
    user_lnk_up = 1'b1;
    flush_mode  = 1'b0;
    rr_m        = 2;

    // Reset pulse in the middle of a ch2 packet.
    push_pkt(2, 4);
    drive();
    build_expected();
    wait_tvalid(10);
    tick();
    sys_reset_n = 1'b0;
    #1;
    chk(tx_cfg_gnt, 1, "mid_rst_cfg_gnt");
    chk(s_axis_tx_tvalid, 0, "mid_rst_tvalid");
    chk(ch_tready, 0, "mid_rst_tready");
    chk(drop_count, 0, "mid_rst_drop");
`ifdef PCIE_TX_ARB_STATS_EN
    chk(pkt_count, 0, "mid_rst_pkt_count");
    for (int c = 0; c < NC; c++) pkt_m[c] = 0;
`endif
    for (int c = 0; c < NC; c++) srcq[c].delete();
    expq.delete();
    fire = '0;
    rr_m = 0;
    drive();
    repeat (2) tick();
    sys_reset_n = 1'b1;
    push_pkt(0, 1);
    push_pkt(2, 1);
    push_pkt(3, 1);
    drive();
    build_expected();
    drain(30);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_tx_arbiter.md
Name: pcie_tx_arbiter

Overview:
- Parametrised N-channel TLP transmit arbiter sitting between user TLP sources and the 7-series PCIe core's AXI4-Stream TX port (s_axis_tx_*), in the core user-clock domain.
- Packet-granular round-robin; gates packet starts on core buffer availability and link state; owns the tx_cfg_req/tx_cfg_gnt handshake; discards in-flight packets on link loss.

Parameters:
- C_DATA_WIDTH, 64, TX data width (64/128/256)
- KEEP_WIDTH, C_DATA_WIDTH/8, tkeep width
- NUM_CHAN, 4, number of source channels (1..8)
- BUF_AV_MIN, 6'd2, minimum tx_buf_av needed to start a packet

Ports:
- sys_clk  in  1  core user clock (user_clk_out)
- sys_reset_n  in  1  asynchronous active-low reset
- user_lnk_up  in  1  core link-up
- tx_buf_av  in  6  core free TX buffers
- tx_cfg_req  in  1  core requests TX for config completion
- tx_cfg_gnt  out  1  grant to core
- ch_tdata  in  NUM_CHAN*C_DATA_WIDTH  channel i at slice i
- ch_tkeep  in  NUM_CHAN*KEEP_WIDTH  per-channel keep
- ch_tuser  in  NUM_CHAN*4  per-channel tuser
- ch_tlast  in  NUM_CHAN  per-channel last
- ch_tvalid  in  NUM_CHAN  per-channel valid
- ch_tready  out  NUM_CHAN  per-channel ready
- s_axis_tx_tdata/tkeep/tuser/tlast/tvalid  out  C_DATA_WIDTH/KEEP_WIDTH/4/1/1  to core
- s_axis_tx_tready  in  1  from core
- drop_count  out  16  packets discarded on link loss (saturating)

Behaviour:
- Reset: async on sys_reset_n low; state IDLE, rr pointer 0, grant 0, drop_count 0, tx_cfg_gnt 1, all tvalid/tready outputs 0.
- States: IDLE, XFER, FLUSH.
- IDLE: tx_cfg_gnt=1. If tx_cfg_req=1, no packet starts (core has priority). Else if user_lnk_up=1, tx_buf_av>=BUF_AV_MIN and any ch_tvalid: select first valid channel at or after rr pointer (wrap at NUM_CHAN-1 -> 0), register grant, go XFER next cycle. 1-cycle arbitration latency.
- XFER: tx_cfg_gnt=0. Data path combinational mux of granted channel onto s_axis_tx_*; ch_tready[g]=s_axis_tx_tready; all other ch_tready=0. On beat (tvalid&tready&tlast): rr pointer=g+1 mod NUM_CHAN, go IDLE. tx_cfg_req during XFER is held off until tlast.
- Packets never interleave; single-beat packets (tlast on first beat) legal.
- Link loss: user_lnk_up=0 in XFER -> FLUSH same cycle; s_axis_tx_tvalid forced 0; ch_tready[g]=1; beats discarded until ch_tlast beat, then drop_count+1 (saturate at 16'hFFFF), rr advance, IDLE.
- Link down in IDLE: no starts; all ch_tready=0.
- tx_buf_av dropping below threshold mid-packet does not stall (core tready governs).
- Simultaneous tx_cfg_req and channel valid in IDLE: cfg wins; arbitration retried each cycle.
- NUM_CHAN=1: pointer constant 0; behaviour otherwise identical.

Optional Feature:
- PCIE_TX_ARB_STATS_EN defined: adds output pkt_count (NUM_CHAN*32), per-channel counter of completed forwarded packets, incremented on tlast beat in XFER, wraps at 2^32, reset 0; flushed packets not counted.
- Undefined: port and counters absent; drop_count unaffected.

Decomposition:
- Shared package pcie_tx_pkg: state encoding (IDLE/XFER/FLUSH), tuser bit positions (discontinue, streamed, src_dsc), DROP_CNT_W=16.
- One sub-module: pcie_rr_pick (combinational round-robin first-set finder, NUM_CHAN-parametrised).

Test Plan:
- Ch0,ch2 valid, 3-beat packets, rr=0, buf_av=10 -> ch0 forwarded fully, then ch2, rr ends at 3; no interleave.
- tx_buf_av=1, BUF_AV_MIN=2, ch1 valid -> no grant; raise buf_av to 2 -> XFER starts one cycle later.
- tx_cfg_req asserted mid-packet on ch3 -> tx_cfg_gnt stays 0 until tlast beat, 1 in IDLE; no new packet while req=1.
- s_axis_tx_tready toggling 1/0 on 4-beat packet -> ch_tready mirrors it; data/keep/tuser bit-exact at output.
- user_lnk_up falls after beat 2 of 5 -> output tvalid 0, remaining 3 beats sunk, drop_count=1.
- sys_reset_n pulsed low mid-XFER -> all outputs reset immediately, tx_cfg_gnt=1, rr=0; with PCIE_TX_ARB_STATS_EN, pkt_count=0.
